// File: rtl/udp_tx_arb_pkg.sv
// rtl/udp_tx_arb_pkg.sv - shared state encoding, widths and round-robin pick for udp_tx_arbiter
package udp_tx_arb_pkg;

    localparam int LEN_W   = 16;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        GAP      = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of mask searching ptr, ptr+1, ... wrapping modulo n (n <= MAX_REQ).
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] mask,
                                         input logic [2:0]         ptr,
                                         input int unsigned        n);
        rr_pick_t   r;
        logic [2:0] k;
        r = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            k = 3'((32'(ptr) + i) % n);
            if (i < n && !r.vld && mask[k]) begin
                r.vld = 1'b1;
                r.idx = k;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/udp_ready_sync.sv
// rtl/udp_ready_sync.sv - 3-flop synchroniser for rgmii_clk flags with a rising-edge pulse output
module udp_ready_sync (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_async,
    output logic o_rise
);

    logic r_s0;
    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s0 <= i_async;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end

    assign o_rise = r_s1 & ~r_s2;

endmodule

// File: rtl/udp_tx_arbiter.sv
// rtl/udp_tx_arbiter.sv - round-robin share of the UDP tx payload port; optional WAIT_ACK timeout via UDP_TX_ARB_TIMEOUT_EN
module udp_tx_arbiter
    import udp_tx_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DW             = 961,
    parameter int GAP_CYCLES     = 64,
    parameter int MAX_LEN        = 120,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                   clk_200m,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DW-1:0]    req_data,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    output logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       reject,
    output logic                   udp_send_data_valid,
    output logic [DW-1:0]          udp_send_data,
    output logic [LEN_W-1:0]       udp_send_data_length,
    input  logic                   udp_ready_async,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int         PTR_W       = $clog2(N_REQ);
    localparam logic [1:0] ST_IDLE     = IDLE;
    localparam logic [1:0] ST_WAIT_ACK = WAIT_ACK;
    localparam logic [1:0] ST_GAP      = GAP;
    localparam logic [1:0] ST_AFTER    = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
    localparam logic [31:0] GAP_LOAD   = 32'(GAP_CYCLES - 1);

    if (N_REQ < 2 || N_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("udp_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    logic [1:0]       r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_grant;
    logic [31:0]      r_gap_cnt;
    logic             r_valid;
    logic [DW-1:0]    r_data;
    logic [LEN_W-1:0] r_len;
    logic [N_REQ-1:0] r_done;
    logic [N_REQ-1:0] r_reject;

    logic             w_ack;
    logic             w_expire;
    rr_pick_t         w_pick;
    logic [PTR_W-1:0] w_idx;
    logic [LEN_W-1:0] w_len;
    logic [DW-1:0]    w_data;
    logic             w_len_ok;

    // Explicit modulo-N_REQ wrap so non-power-of-two requester counts rotate correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_REQ - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    udp_ready_sync u_ready_sync (
        .i_clk   (clk_200m),
        .i_rstn  (rstn),
        .i_async (udp_ready_async),
        .o_rise  (w_ack)
    );

    assign w_pick   = rr_pick(MAX_REQ'(req), 3'(r_ptr), unsigned'(N_REQ));
    assign w_idx    = PTR_W'(w_pick.idx);
    assign w_len    = req_len[int'(w_idx)*LEN_W +: LEN_W];
    assign w_data   = req_data[int'(w_idx)*DW +: DW];
    assign w_len_ok = (w_len != '0) && (w_len <= LEN_W'(MAX_LEN));

`ifdef UDP_TX_ARB_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        r_timeout_err;

    assign w_expire = (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Counter sits at zero outside WAIT_ACK, so it is already cleared on entry.
    always_ff @(posedge clk_200m) begin
        if (!rstn) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= (r_state == ST_WAIT_ACK) && w_expire && !w_ack;
            if (r_state != ST_WAIT_ACK) begin
                r_to_cnt <= '0;
            end else if (!w_expire) begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_expire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk_200m) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_gap_cnt <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_len     <= '0;
            r_done    <= '0;
            r_reject  <= '0;
        end else begin
            r_done   <= '0;
            r_reject <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick.vld) begin
                        if (w_len_ok) begin
                            r_data  <= w_data;
                            r_len   <= w_len;
                            r_valid <= 1'b1;
                            r_grant <= w_idx;
                            r_state <= ST_WAIT_ACK;
                        end else begin
                            r_reject[w_idx] <= 1'b1;
                            r_ptr           <= ptr_inc(w_idx);
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    // An ack in the expiry cycle completes the packet normally.
                    if (w_ack || w_expire) begin
                        r_valid         <= 1'b0;
                        r_done[r_grant] <= 1'b1;
                        r_ptr           <= ptr_inc(r_grant);
                        r_gap_cnt       <= GAP_LOAD;
                        r_state         <= ST_AFTER;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 32'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign done                 = r_done;
    assign reject               = r_reject;
    assign udp_send_data_valid  = r_valid;
    assign udp_send_data        = r_data;
    assign udp_send_data_length = r_len;
    assign busy                 = (r_state != ST_IDLE);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb/tb_udp_tx_arbiter.sv - self-checking bench for udp_tx_arbiter (timeout cases when UDP_TX_ARB_TIMEOUT_EN is defined)
`timescale 1ns/1ps
module tb_udp_tx_arbiter;

    localparam int N    = 4;
    localparam int DW   = 961;
    localparam int GAP  = 64;
    localparam int MAXL = 120;
`ifdef UDP_TX_ARB_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 200000;
`endif

    logic            clk_200m = 1'b0;
    logic            rstn     = 1'b0;
    logic [N-1:0]    req      = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N*16-1:0] req_len  = '0;
    logic [N-1:0]    done;
    logic [N-1:0]    reject;
    logic            valid;
    logic [DW-1:0]   udata;
    logic [15:0]     ulen;
    logic            ready    = 1'b0;
    logic            busy;
    logic            timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_200m = ~clk_200m;

    udp_tx_arbiter #(
        .N_REQ(N), .DW(DW), .GAP_CYCLES(GAP), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_200m             (clk_200m),
        .rstn                 (rstn),
        .req                  (req),
        .req_data             (req_data),
        .req_len              (req_len),
        .done                 (done),
        .reject               (reject),
        .udp_send_data_valid  (valid),
        .udp_send_data        (udata),
        .udp_send_data_length (ulen),
        .udp_ready_async      (ready),
        .busy                 (busy),
        .timeout_err          (timeout_err)
    );

    typedef struct {
        logic [3:0]  rq;
        logic [15:0] len;
        logic        rej;
        int          idx;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got low64 %h expected low64 %h", name, got[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int seed);
        logic [DW-1:0] v;
        v = '0;
        for (int w = 0; w < 31; w++)
            v = (v << 32) | DW'(32'hA5C3_0000 ^ (32'(seed) * 32'h9E37_79B9) ^ 32'(w));
        v[DW-1] = ~v[0];
        return v;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] v;
        v = '0;
        for (int w = 0; w < 31; w++) v = (v << 32) | DW'($urandom);
        return v;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    task automatic tick();
        @(posedge clk_200m);
        #1;
    endtask

    task automatic set_all(input logic [15:0] len);
        for (int i = 0; i < N; i++) begin
            req_len[i*16 +: 16]  = len;
            req_data[i*DW +: DW] = pat(i);
        end
    endtask

    // Ready raised just after an edge; done is expected on the third following edge.
    task automatic ack_and_gap(input int idx);
        int k;
        int nb;
        ready = 1'b1;
        k = 0;
        do begin tick(); k++; end while (done == '0 && k < 8);
        chk("ack_latency", 64'(k), 64'(3));
        chk("done_onehot", 64'(done), 64'(oh(idx)));
        chk("valid_drop", 64'(valid), 64'(0));
        req   = '0;
        ready = 1'b0;
        nb    = 0;
        while (busy && nb < 200) begin nb++; tick(); end
        chk("gap_busy_cycles", 64'(nb), 64'(GAP));
    endtask

    // Reference model state for the randomized phase
    int            mptr, next_idle, mg, rise_en, g_en, en, npkt, idx;
    bit            waiting;
    bit            pend[N];
    int            plen[N];
    logic [DW-1:0] pdata[N];

    initial begin
        tbl[0]  = '{4'b0100, 16'd0,      1'b1, 2};
        tbl[1]  = '{4'b0100, 16'd121,    1'b1, 2};
        tbl[2]  = '{4'b0100, 16'd120,    1'b0, 2};
        tbl[3]  = '{4'b0011, 16'd1,      1'b0, 0};
        tbl[4]  = '{4'b0011, 16'd64,     1'b0, 1};
        tbl[5]  = '{4'b1001, 16'hFFFF,   1'b1, 3};
        tbl[6]  = '{4'b1010, 16'd7,      1'b0, 1};
        tbl[7]  = '{4'b0001, 16'd120,    1'b0, 0};
        tbl[8]  = '{4'b1111, 16'd64,     1'b0, 1};
        tbl[9]  = '{4'b1111, 16'd64,     1'b0, 2};
        tbl[10] = '{4'b1111, 16'd64,     1'b0, 3};
        tbl[11] = '{4'b1111, 16'd64,     1'b0, 0};

        rstn = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_reject", 64'(reject), 64'(0));
        chk("rst_len", 64'(ulen), 64'(0));
        chk_data("rst_data", udata, '0);
        chk("rst_timeout", 64'(timeout_err), 64'(0));
        rstn = 1'b1;
        tick();

        for (int t = 0; t < 12; t++) begin
            set_all(tbl[t].len);
            req = tbl[t].rq;
            tick();
            if (tbl[t].rej) begin
                chk("tbl_reject", 64'(reject), 64'(oh(tbl[t].idx)));
                chk("tbl_rej_valid", 64'(valid), 64'(0));
                chk("tbl_rej_busy", 64'(busy), 64'(0));
                req = '0;
                tick();
                chk("tbl_rej_pulse", 64'(reject), 64'(0));
            end else begin
                chk("tbl_valid", 64'(valid), 64'(1));
                chk("tbl_reject0", 64'(reject), 64'(0));
                chk("tbl_len", 64'(ulen), 64'(tbl[t].len));
                chk_data("tbl_data", udata, pat(tbl[t].idx));
                ack_and_gap(tbl[t].idx);
            end
        end

        // Payload latched in WAIT_ACK survives changed data and a dropped req
        set_all(16'd33);
        req = 4'b0010;
        tick();
        chk("stab_valid", 64'(valid), 64'(1));
        req_data[1*DW +: DW] = ~pat(1);
        req = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_data("stab_data", udata, pat(1));
            chk("stab_len", 64'(ulen), 64'(33));
            chk("stab_hold", 64'(valid), 64'(1));
        end
        ack_and_gap(1);

        begin
            logic seen;
            seen  = 1'b0;
            ready = 1'b1;
            for (int c = 0; c < 6; c++) begin
                tick();
                seen = seen | (done != '0) | busy | valid;
            end
            chk("spurious_ready", 64'(seen), 64'(0));
            ready = 1'b0;
            for (int c = 0; c < 4; c++) tick();
        end

        // Reset in WAIT_ACK with ptr at 2; afterwards ptr must restart from 0
        set_all(16'd50);
        req = 4'b1000;
        tick();
        chk("rmid_grant", 64'(valid), 64'(1));
        chk_data("rmid_data", udata, pat(3));
        rstn = 1'b0;
        tick();
        chk("rmid_valid", 64'(valid), 64'(0));
        chk("rmid_done", 64'(done), 64'(0));
        chk("rmid_busy", 64'(busy), 64'(0));
        rstn = 1'b1;
        req  = 4'b1001;
        tick();
        chk("rmid_ptr0", 64'(valid), 64'(1));
        chk_data("rmid_ptr0_data", udata, pat(0));
        ack_and_gap(0);
        req = 4'b1000;
        tick();
        chk("rmid_req3", 64'(valid), 64'(1));
        chk_data("rmid_req3_data", udata, pat(3));
        ack_and_gap(3);

`ifdef UDP_TX_ARB_TIMEOUT_EN
        begin
            int k;
            req = 4'b0001;
            tick();
            chk("to_valid", 64'(valid), 64'(1));
            k = 0;
            while (valid && k < 300) begin tick(); k++; end
            chk("to_latency", 64'(k), 64'(TO));
            chk("to_err", 64'(timeout_err), 64'(1));
            chk("to_done", 64'(done), 64'(oh(0)));
            req = 4'b0010;
            k = 0;
            while (!valid && k < 300) begin tick(); k++; end
            chk("to_regrant_gap", 64'(k), 64'(GAP + 1));
            chk_data("to_regrant_data", udata, pat(1));
            for (int c = 0; c < TO - 3; c++) tick();
            ready = 1'b1;
            tick();
            tick();
            tick();
            chk("to_ack_done", 64'(done), 64'(oh(1)));
            chk("to_ack_noerr", 64'(timeout_err), 64'(0));
            chk("to_ack_valid", 64'(valid), 64'(0));
            ready = 1'b0;
            req   = '0;
            k = 0;
            while (busy && k < 200) begin tick(); k++; end
        end
`else
        begin
            logic lost;
            lost = 1'b0;
            req  = 4'b0001;
            tick();
            for (int c = 0; c < 300; c++) begin
                tick();
                lost = lost | ~valid | timeout_err | (done != '0);
            end
            chk("no_timeout_wait", 64'(lost), 64'(0));
            ack_and_gap(0);
        end
`endif

        // Randomized phase against a transaction-level model
        req   = '0;
        ready = 1'b0;
        rstn  = 1'b0;
        tick();
        rstn      = 1'b1;
        en        = 0;
        mptr      = 0;
        next_idle = 1;
        waiting   = 1'b0;
        rise_en   = -1;
        npkt      = 0;
        mg        = 0;
        g_en      = 0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;

        for (int it = 0; it < 12000 && npkt < 40; it++) begin
            tick();
            en++;
            if (waiting && rise_en >= 0 && en == rise_en + 3) begin
                chk("rnd_done", 64'(done), 64'(oh(mg)));
                chk("rnd_done_valid", 64'(valid), 64'(0));
                waiting   = 1'b0;
                next_idle = en + GAP + 1;
                mptr      = (mg + 1) % N;
                pend[mg]  = 1'b0;
                ready     = 1'b0;
                rise_en   = -1;
                npkt++;
            end else begin
                chk("rnd_no_done", 64'(done), 64'(0));
                if (!waiting && en >= next_idle && req != '0) begin
                    idx = -1;
                    for (int k = 0; k < N; k++)
                        if (idx < 0 && req[(mptr + k) % N]) idx = (mptr + k) % N;
                    if (plen[idx] >= 1 && plen[idx] <= MAXL) begin
                        chk("rnd_grant_valid", 64'(valid), 64'(1));
                        chk("rnd_grant_rej", 64'(reject), 64'(0));
                        chk("rnd_len", 64'(ulen), 64'(plen[idx]));
                        chk_data("rnd_data", udata, pdata[idx]);
                        waiting = 1'b1;
                        mg      = idx;
                        g_en    = en;
                    end else begin
                        chk("rnd_reject", 64'(reject), 64'(oh(idx)));
                        chk("rnd_rej_valid", 64'(valid), 64'(0));
                        next_idle = en + 1;
                        mptr      = (idx + 1) % N;
                        pend[idx] = 1'b0;
                    end
                end else begin
                    chk("rnd_quiet", 64'({reject, valid}), 64'({4'b0, waiting}));
                end
            end
            chk("rnd_busy", 64'(busy), 64'(waiting || en < next_idle - 1));
            chk("rnd_timeout", 64'(timeout_err), 64'(0));

            if (waiting && !ready && ($urandom_range(0, 2) == 0 || en - g_en > 20)) begin
                ready   = 1'b1;
                rise_en = en;
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 5) == 0) begin
                    pend[i] = 1'b1;
                    case ($urandom_range(0, 9))
                        0:       plen[i] = 0;
                        1:       plen[i] = 121 + $urandom_range(0, 1000);
                        2:       plen[i] = 120;
                        3:       plen[i] = 1;
                        default: plen[i] = $urandom_range(1, 120);
                    endcase
                    pdata[i]             = rnd_data();
                    req_len[i*16 +: 16]  = 16'(plen[i]);
                    req_data[i*DW +: DW] = pdata[i];
                end
                req[i] = pend[i];
            end
        end
        chk("rnd_progress", 64'(npkt >= 20), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit payload port of the Ethernet UDP engine between N requesters in the clk_200m domain.
- Performs round-robin grant, then presents payload and length with a level valid held until the engine's ready acknowledge.
- The ready acknowledge arrives asynchronously from the rgmii_clk domain; the block synchronises it and edge-detects it.
- After each packet, enforces a programmable inter-packet gap before the next grant.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 961, payload bus width per requester.
- GAP_CYCLES, 64, idle clk_200m cycles after each packet (0 allowed).
- MAX_LEN, 120, largest legal length in bytes; lengths 0 or >MAX_LEN are rejected.
- TIMEOUT_CYCLES, 200000, WAIT_ACK limit (used only with optional feature).

Ports:
- clk_200m  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- req  in  N_REQ  per-requester send request (level).
- req_data  in  N_REQ*DW  payloads; requester i uses slice [i*DW +: DW].
- req_len  in  N_REQ*16  lengths; requester i uses slice [i*16 +: 16].
- done  out  N_REQ  one-cycle completion pulse to the granted requester.
- reject  out  N_REQ  one-cycle pulse; the request was dropped for an illegal length.
- udp_send_data_valid  out  1  level valid to the UDP engine.
- udp_send_data  out  DW  registered payload.
- udp_send_data_length  out  16  registered length.
- udp_ready_async  in  1  engine ready, rgmii_clk domain.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse on WAIT_ACK timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; synchroniser flops 0; gap counter 0.
- Reset asserted mid-packet abandons the packet: valid drops the cycle after the reset edge, and no done pulse is issued.
- Ack detection:
  - Three flops: s0 <= udp_ready_async, s1 <= s0, s2 <= s1.
  - ack = s1 & ~s2, so ack is 2-3 cycles after the async rising edge.
  - ack outside WAIT_ACK is ignored.
- State IDLE:
  - If any req bit is high, pick the first set bit searching from ptr, ptr+1, ... wrapping modulo N_REQ.
  - Illegal length (0 or >MAX_LEN): pulse reject[g] next cycle, set ptr <= g+1, stay IDLE.
  - Legal length: register the data and length slices, valid <= 1, grant <= g, state WAIT_ACK.
  - valid is therefore high 1 cycle after req is sampled.
- State WAIT_ACK:
  - valid, data and length are held constant.
  - Changes to req or req_data during WAIT_ACK are ignored; the latched copy is sent.
  - On ack: valid <= 0, done[grant] <= 1, ptr <= grant+1 (wraps).
  - Next state is GAP with cnt <= GAP_CYCLES-1, or IDLE directly if GAP_CYCLES == 0.
- State GAP: decrement cnt each cycle; when cnt == 0, go to IDLE. Requests are not sampled during GAP.
- ack and a new req in the same cycle: ack is handled first; the new req waits until IDLE.
- A requester must hold req until it sees done or reject. A req still high in IDLE after its done is treated as a new packet.
- busy = (state != IDLE).
- Widths: length compare is unsigned 16-bit. ptr is $clog2(N_REQ) bits, and wrap is explicit (modulo N_REQ, not power-of-two overflow).

Optional Feature:
- Macro UDP_TX_ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
  - At TIMEOUT_CYCLES-1: valid <= 0, timeout_err pulses 1 cycle, done[grant] pulses, ptr advances, state goes to GAP.
  - If ack and expiry occur in the same cycle, ack wins and there is no timeout_err.
- Undefined: WAIT_ACK waits indefinitely; timeout_err is tied 0; no counter logic is generated.

Decomposition:
- Package udp_tx_arb_pkg: state enum (IDLE, WAIT_ACK, GAP), localparam LEN_W = 16, and the round-robin pick function (mask, pointer -> index, valid).
- One sub-module, udp_ready_sync: 3-flop synchroniser with rising-edge pulse output, reset to 0. It is reused for other rgmii_clk -> clk_200m flags.

Test Plan:
- Single request: req[0]=1, len=64, data pattern A. Expect valid high 1 cycle later with data=A and length=64. Async ready pulse -> done[0] within 4 cycles, valid low, busy high for 64 further cycles.
- Round robin: req=4'b1111 held, each packet acked. Expect grant order 0,1,2,3,0, with ≥64 idle cycles between valids.
- Illegal length: req[2] with len=0, then len=121. Expect reject[2] pulse each time, valid never asserted, busy stays 0.
- Stability: change req_data[1] and drop req[1] during WAIT_ACK. Expect the output payload unchanged and done[1] on ack. Spurious ready in IDLE -> no done.
- Reset mid-packet: rstn=0 in WAIT_ACK. Expect valid, done and busy all 0 next cycle, ptr=0. After release, req[3] is granted normally.
- With UDP_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, no ready: timeout_err and done pulse together, valid low, and the next requester is granted after GAP. Ready at the expiry cycle -> no timeout_err.
